// File: rtl/control_unit.sv
// Instruction-sequencing FSM: decodes IR into bus selects, load enables, AddSub and Done.
// Optional macro CU_ILLEGAL_OP_EN adds the Illegal flag and the sticky IllegalSeen output.
module control_unit #(
  parameter int IRW       = 9,
  parameter bit R0_AT_MSB = 1'b1
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Run,
  input  logic [IRW-1:0] IR,
  output logic           IRin,
  output logic [7:0]     Rin,
  output logic           Ain,
  output logic           Gin,
  output logic           AddSub,
  output logic [7:0]     selectR,
  output logic           selectG,
  output logic           selectDin,
  output logic           Done
`ifdef CU_ILLEGAL_OP_EN
  ,
  output logic           Illegal,
  output logic           IllegalSeen
`endif
);

  generate
    if (IRW != 9) begin : g_bad_irw
      $error("control_unit: IRW must be 9");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state, state_next;
  logic [2:0] opcode, rx, ry;
  logic       is_arith;
  logic       illegal_t1;

  assign opcode   = IR[8:6];
  assign rx       = IR[5:3];
  assign ry       = IR[2:0];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

  // Bit ordering of the one-hot register vectors follows the bus mux wiring.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = R0_AT_MSB ? (8'h80 >> idx) : (8'h01 << idx);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = Run ? T1 : IDLE;
      T1:      state_next = is_arith ? T2 : IDLE;
      T2:      state_next = T3;
      T3:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IRin       = 1'b0;
    Rin        = 8'h00;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    selectR    = 8'h00;
    selectG    = 1'b0;
    selectDin  = 1'b0;
    Done       = 1'b0;
    illegal_t1 = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: IRin = Run;
        T1: begin
          case (opcode)
            OP_MV: begin
              selectR = onehot(ry);
              Rin     = onehot(rx);
              Done    = 1'b1;
            end
            OP_MVI: begin
              selectDin = 1'b1;
              Rin       = onehot(rx);
              Done      = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              selectR = onehot(rx);
              Ain     = 1'b1;
            end
            default: begin
              Done       = 1'b1;
              illegal_t1 = 1'b1;
            end
          endcase
        end
        T2: begin
          selectR = onehot(ry);
          Gin     = 1'b1;
          AddSub  = opcode[0];
        end
        T3: begin
          selectG = 1'b1;
          Rin     = onehot(rx);
          Done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CU_ILLEGAL_OP_EN
  logic illegal_seen_q;

  always_ff @(posedge Clock) begin
    if (Reset)           illegal_seen_q <= 1'b0;
    else if (illegal_t1) illegal_seen_q <= 1'b1;
  end

  assign Illegal     = illegal_t1;
  // Gated so every output reads 0 while Reset is held, before the clearing edge.
  assign IllegalSeen = illegal_seen_q & ~Reset;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_t1;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, multi-cycle sequences, random vs schedule model.
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run   = 1'b0;
  logic [8:0] IR    = 9'h000;
  logic       IRin, Ain, Gin, AddSub, selectG, selectDin, Done;
  logic [7:0] Rin, selectR;
`ifdef CU_ILLEGAL_OP_EN
  localparam logic ILL = 1'b1;
  logic Illegal, IllegalSeen;
`else
  localparam logic ILL = 1'b0;
`endif

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR),
    .IRin(IRin), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .selectR(selectR), .selectG(selectG), .selectDin(selectDin), .Done(Done)
`ifdef CU_ILLEGAL_OP_EN
    , .Illegal(Illegal), .IllegalSeen(IllegalSeen)
`endif
  );

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic [7:0] selr;
    logic       selg;
    logic       seldin;
    logic       done;
    logic       ill;
    logic       seen;
  } out_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [8:0] ir;
    out_t       exp;
  } vec_t;

  int tests = 0;
  int fails = 0;
  out_t q[$];

  function automatic out_t e(input logic irin, input logic [7:0] rin, input logic ain, input logic gin,
                             input logic addsub, input logic [7:0] selr, input logic selg,
                             input logic seldin, input logic done, input logic ill, input logic seen);
    out_t o;
    o.irin = irin; o.rin = rin; o.ain = ain; o.gin = gin; o.addsub = addsub;
    o.selr = selr; o.selg = selg; o.seldin = seldin; o.done = done; o.ill = ill; o.seen = seen;
    return o;
  endfunction

  // Register r is bit (7 - r): R0 at the MSB.
  function automatic logic [7:0] oh(input logic [2:0] r);
    logic [7:0] v;
    v = '0;
    v[7 - int'(r)] = 1'b1;
    return v;
  endfunction

  function automatic out_t sample();
    out_t a;
    a = e(IRin, Rin, Ain, Gin, AddSub, selectR, selectG, selectDin, Done, 1'b0, 1'b0);
`ifdef CU_ILLEGAL_OP_EN
    a.ill  = Illegal;
    a.seen = IllegalSeen;
`endif
    return a;
  endfunction

  task automatic drive(input logic rst, input logic run, input logic [8:0] ir);
    @(negedge Clock);
    Reset = rst;
    Run   = run;
    IR    = ir;
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Per-cycle expectations for one instruction, from the opcode table.
  task automatic push_instr(input logic [8:0] ir);
    logic [2:0] op, rx, ry;
    op = ir[8:6]; rx = ir[5:3]; ry = ir[2:0];
    case (op)
      3'b000: q.push_back(e(0, oh(rx), 0, 0, 0, oh(ry), 0, 0, 1, 0, 0));
      3'b001: q.push_back(e(0, oh(rx), 0, 0, 0, 8'h00, 0, 1, 1, 0, 0));
      3'b010, 3'b011: begin
        q.push_back(e(0, 8'h00, 1, 0, 0, oh(rx), 0, 0, 0, 0, 0));
        q.push_back(e(0, 8'h00, 0, 1, op[0], oh(ry), 0, 0, 0, 0, 0));
        q.push_back(e(0, oh(rx), 0, 0, 0, 8'h00, 1, 0, 1, 0, 0));
      end
      default: q.push_back(e(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, ILL, 0));
    endcase
  endtask

  localparam logic [8:0] MVI_R2   = 9'b001_010_000;
  localparam logic [8:0] MV_R7_R0 = 9'b000_111_000;
  localparam logic [8:0] SUB_R3R5 = 9'b011_011_101;
  localparam logic [8:0] ILL_OP   = 9'b110_000_000;
  localparam logic [8:0] ADD_R0R1 = 9'b010_000_001;
  localparam logic [8:0] MV_R1_R2 = 9'b000_001_010;
  localparam logic [8:0] MV_R4_R0 = 9'b000_100_000;

  initial begin
    vec_t vt[15];
    out_t z, exp;
    logic rst, run;
    logic [8:0] rir;
    logic mseen;
    int d1, d2, between;
    logic [8:0] cur;

    z = '0;
    vt[0]  = '{1, 1, 9'h000,   z};
    vt[1]  = '{0, 1, MVI_R2,   e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    vt[2]  = '{0, 0, MVI_R2,   e(0, 8'b00100000, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0)};
    vt[3]  = '{0, 0, MV_R7_R0, z};
    vt[4]  = '{0, 1, MV_R7_R0, e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    vt[5]  = '{0, 0, MV_R7_R0, e(0, 8'b00000001, 0, 0, 0, 8'b10000000, 0, 0, 1, 0, 0)};
    vt[6]  = '{0, 1, SUB_R3R5, e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    vt[7]  = '{0, 0, SUB_R3R5, e(0, 8'h00, 1, 0, 0, 8'b00010000, 0, 0, 0, 0, 0)};
    vt[8]  = '{0, 1, SUB_R3R5, e(0, 8'h00, 0, 1, 1, 8'b00000100, 0, 0, 0, 0, 0)};
    vt[9]  = '{0, 0, SUB_R3R5, e(0, 8'b00010000, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0)};
    vt[10] = '{0, 1, ILL_OP,   e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    vt[11] = '{0, 0, ILL_OP,   e(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, ILL, 0)};
    vt[12] = '{0, 0, ILL_OP,   e(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, ILL)};
    vt[13] = '{1, 1, ILL_OP,   z};
    vt[14] = '{0, 0, ILL_OP,   z};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].run, vt[i].ir);
      check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Reset during T2 of add abandons it; a following mv runs normally.
    drive(0, 1, ADD_R0R1); check("rst_seq_fetch", e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    drive(0, 0, ADD_R0R1); check("rst_seq_t1", e(0, 8'h00, 1, 0, 0, 8'h80, 0, 0, 0, 0, 0));
    drive(1, 0, ADD_R0R1); check("rst_seq_in_t2", z);
    drive(0, 0, MV_R1_R2); check("rst_seq_idle", z);
    drive(0, 1, MV_R1_R2); check("rst_seq_mv_fetch", e(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    drive(0, 0, MV_R1_R2); check("rst_seq_mv_t1", e(0, 8'h40, 0, 0, 0, 8'h20, 0, 0, 1, 0, 0));

    // Run held high across add then mv: one fetch cycle between Done pulses.
    d1 = -1; d2 = -1; between = 0; cur = ADD_R0R1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, cur);
      if (d1 >= 0 && d2 < 0 && IRin) between++;
      if (Done) begin
        if (d1 < 0) begin d1 = k; cur = MV_R4_R0; end
        else if (d2 < 0) d2 = k;
      end
      if (d2 >= 0) break;
    end
    drive(0, 0, cur);
    check_int("held_add_done_latency", d1, 3);
    check_int("held_done_gap", d2 - d1, 2);
    check_int("held_fetch_cycles", between, 1);

    // Random run against the schedule model.
    q.delete();
    mseen = 1'b0;
    rir = 9'h000;
    for (int c = 0; c < 2000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 49) == 0);
      run = 1'($urandom_range(0, 1));
      if (q.size() == 0) rir = 9'($urandom);
      drive(rst, run, rir);
      if (rst) exp = '0;
      else if (q.size() == 0) begin
        exp = '0;
        exp.irin = run;
        exp.seen = mseen;
        if (run) push_instr(rir);
      end else begin
        exp = q.pop_front();
        exp.seen = mseen;
      end
      check($sformatf("random%0d", c), exp);
      if (rst) begin
        q.delete();
        mseen = 1'b0;
      end else if (exp.ill) mseen = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
